rotate_issue_queue: RTL and testbench

Buffered issue stage directly upstream of the 4-bit barrel shifter. It accepts {data, shift amount} commands over a valid/ready handshake and queues them in a small FIFO. It drives the shifter's combinational data/select inputs from registers, captures the shifter output one cycle later, and presents the result on a valid/ready output port. The shifter itself stays outside this block and is connected through the `sh_*` ports.

---
 rtl/rotq_pkg.sv | 12 +
 rtl/rotq_fifo.sv | 66 ++++++
 rtl/rotate_issue_queue.sv | 107 ++++++++++
 tb/tb_rotate_issue_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rotq_pkg.sv
// Shared widths and command payload for the rotate issue queue.
package rotq_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned AMT_W  = 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
   } rotq_cmd_t;

endpackage : rotq_pkg

// File: rtl/rotq_fifo.sv
// Synchronous command FIFO; owns read/write pointers and the occupancy count.
// No same-cycle bypass: an entry is visible at head only after the push edge.
module rotq_fifo
   import rotq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rotq_cmd_t                push_data,
   input  logic                     pop,
   output rotq_cmd_t                head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   rotq_cmd_t          mem_q [DEPTH];
   rotq_cmd_t          mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : rotq_fifo

// File: rtl/rotate_issue_queue.sv
// Buffered issue stage in front of an external 4-bit barrel shifter:
// command FIFO -> registered shifter drive -> captured result with valid/ready.
module rotate_issue_queue
   import rotq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [DATA_W-1:0]        cmd_data,
   input  logic [AMT_W-1:0]         cmd_amt,
   output logic [DATA_W-1:0]        sh_i,
   output logic [AMT_W-1:0]         sh_s,
   input  logic [DATA_W-1:0]        sh_o,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DATA_W-1:0]        res_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   rotq_cmd_t          push_cmd;
   rotq_cmd_t          head;
   logic [CNT_W-1:0]   count;
   logic               push;
   logic               pop;
   logic               capture;

   logic [DATA_W-1:0]  sh_i_q, sh_i_d;
   logic [AMT_W-1:0]   sh_s_q, sh_s_d;
   logic               d_valid_q, d_valid_d;
   logic [DATA_W-1:0]  res_data_q, res_data_d;
   logic               res_valid_q, res_valid_d;

   // Ready is a function of registered occupancy only.
   assign cmd_ready     = (count != CNT_W'(DEPTH));
   assign push          = cmd_valid && cmd_ready;
   assign push_cmd.data = cmd_data;
   assign push_cmd.amt  = cmd_amt;

   // Capture frees the drive stage, so a pop may refill it in the same cycle.
   assign capture = d_valid_q && (!res_valid_q || res_ready);
   assign pop     = (count != '0) && (!d_valid_q || capture);

   rotq_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // Drive and result stage next-state; drive regs hold when not popping.
   always_comb begin
      sh_i_d      = sh_i_q;
      sh_s_d      = sh_s_q;
      d_valid_d   = d_valid_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      if (pop) begin
         sh_i_d    = head.data;
         sh_s_d    = head.amt;
         d_valid_d = 1'b1;
      end else if (capture) begin
         d_valid_d = 1'b0;
      end
      if (capture) begin
         res_data_d  = sh_o;
         res_valid_d = 1'b1;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_i_q      <= '0;
         sh_s_q      <= '0;
         d_valid_q   <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
      end else begin
         sh_i_q      <= sh_i_d;
         sh_s_q      <= sh_s_d;
         d_valid_q   <= d_valid_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign sh_i       = sh_i_q;
   assign sh_s       = sh_s_q;
   assign res_data   = res_data_q;
   assign res_valid  = res_valid_q;
   assign fifo_count = count;
   assign busy       = (count != '0) || d_valid_q || res_valid_q;

endmodule : rotate_issue_queue

// File: tb/tb_rotate_issue_queue.sv
// Directed bench for rotate_issue_queue with an XOR stand-in for the shifter.
module tb_rotate_issue_queue;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic [1:0] cmd_amt;
   logic [3:0] sh_i;
   logic [1:0] sh_s;
   logic [3:0] sh_o;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic [2:0] fifo_count;
   logic       busy;

   logic       rr_main;
   logic       alt_en;
   logic       alt_ph = 1'b0;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   logic [3:0] exp_q[$];
   logic [3:0] xfer_dat[$];
   int         xfer_cyc[$];

   always #5 clk = ~clk;

   assign sh_o      = sh_i ^ {2'b00, sh_s};
   assign res_ready = alt_en ? alt_ph : rr_main;

   rotate_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_data   (cmd_data),
      .cmd_amt    (cmd_amt),
      .sh_i       (sh_i),
      .sh_s       (sh_s),
      .sh_o       (sh_o),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle counter and alternating ready phase.
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      alt_ph <= ~alt_ph;
   end

   // Scoreboard: compare every result transfer against accepted commands in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check_val("sb_extra", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
               check_val("sb_order", 32'(res_data), 32'(exp_q.pop_front()));
            end
            xfer_dat.push_back(res_data);
            xfer_cyc.push_back(cyc);
         end
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(cmd_data ^ {2'b00, cmd_amt});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic [1:0] a);
      int   n;
      logic acc;
      n         = 0;
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_amt   = a;
      do begin
         acc = cmd_ready;
         tick();
         n++;
      end while (!acc && n < 50);
      if (!acc) check_val("send_timeout", 32'(acc), 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_xfers(input int n, input int budget);
      int k;
      k = 0;
      while (xfer_dat.size() < n && k < budget) begin
         tick();
         k++;
      end
      check_val("xfer_cnt", 32'(xfer_dat.size()), 32'(n));
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check_val({tag, "_count"},     32'(fifo_count), 32'd0);
      check_val({tag, "_busy"},      32'(busy), 32'd0);
      check_val({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check_val({tag, "_res_data"},  32'(res_data), 32'd0);
      check_val({tag, "_sh_i"},      32'(sh_i), 32'd0);
      check_val({tag, "_sh_s"},      32'(sh_s), 32'd0);
   endtask

   logic [3:0] t2_exp [6];
   logic [3:0] t3_dat [6];
   logic [1:0] t3_amt [6];
   logic [3:0] t3_exp [6];

   initial begin
      t2_exp = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h7, 4'h6};
      t3_dat = '{4'h9, 4'h4, 4'hE, 4'h7, 4'h2, 4'hC};
      t3_amt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
      t3_exp = '{4'h8, 4'h6, 4'hD, 4'h7, 4'h0, 4'hD};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_amt   = '0;
      rr_main   = 1'b0;
      alt_en    = 1'b0;
      #12;
      check_reset_vals("rst");
      tick();
      rst_n = 1'b1;
      tick();

      // 1: single command, latency
      cmd_valid = 1'b1; cmd_data = 4'hA; cmd_amt = 2'd1; rr_main = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check_val("t1_count_e0", 32'(fifo_count), 32'd1);
      check_val("t1_busy_e0",  32'(busy), 32'd1);
      tick();
      check_val("t1_sh_i_e1",  32'(sh_i), 32'hA);
      check_val("t1_sh_s_e1",  32'(sh_s), 32'd1);
      check_val("t1_count_e1", 32'(fifo_count), 32'd0);
      check_val("t1_rv_e1",    32'(res_valid), 32'd0);
      tick();
      check_val("t1_rv_e2",    32'(res_valid), 32'd1);
      check_val("t1_rd_e2",    32'(res_data), 32'hB);
      tick();
      check_val("t1_rv_e3",    32'(res_valid), 32'd0);
      check_val("t1_busy_e3",  32'(busy), 32'd0);

      // 2: burst, one result per cycle
      repeat (2) tick();
      xfer_dat.delete(); xfer_cyc.delete();
      for (int i = 0; i < 6; i++) send(4'(i), 2'd3);
      wait_xfers(6, 30);
      for (int i = 0; i < 6 && i < xfer_dat.size(); i++) begin
         check_val("t2_data", 32'(xfer_dat[i]), 32'(t2_exp[i]));
         check_val("t2_b2b",  32'(xfer_cyc[i] - xfer_cyc[0]), 32'(i));
      end

      // 3: backpressure fills the FIFO
      repeat (2) tick();
      rr_main = 1'b0;
      xfer_dat.delete(); xfer_cyc.delete();
      for (int i = 0; i < 6; i++) send(t3_dat[i], t3_amt[i]);
      check_val("t3_count_full", 32'(fifo_count), 32'd4);
      check_val("t3_ready_low",  32'(cmd_ready), 32'd0);
      check_val("t3_sh_i",       32'(sh_i), 32'h4);
      check_val("t3_sh_s",       32'(sh_s), 32'd2);
      check_val("t3_rv",         32'(res_valid), 32'd1);
      check_val("t3_rd",         32'(res_data), 32'h8);

      // 4: push attempts while full are ignored, stall holds everything
      cmd_valid = 1'b1; cmd_data = 4'hF; cmd_amt = 2'd0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val("t4_count", 32'(fifo_count), 32'd4);
         check_val("t4_sh_i",  32'(sh_i), 32'h4);
         check_val("t4_rd",    32'(res_data), 32'h8);
         check_val("t4_rv",    32'(res_valid), 32'd1);
      end
      cmd_valid = 1'b0;
      rr_main   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_val("t3_drain_count", 32'(fifo_count), 32'(3 - k));
      end
      wait_xfers(6, 30);
      for (int i = 0; i < 6 && i < xfer_dat.size(); i++) begin
         check_val("t3_data", 32'(xfer_dat[i]), 32'(t3_exp[i]));
      end
      repeat (3) tick();
      check_val("t4_no_extra", 32'(xfer_dat.size()), 32'd6);

      // 5: reset with queued, in-flight and held results
      rr_main = 1'b0;
      xfer_dat.delete(); xfer_cyc.delete();
      for (int i = 1; i <= 5; i++) send(4'(i), 2'd0);
      check_val("t5_count_pre", 32'(fifo_count), 32'd3);
      check_val("t5_rv_pre",    32'(res_valid), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_vals("t5");
      tick(); tick();
      rst_n   = 1'b1;
      rr_main = 1'b1;
      repeat (5) tick();
      check_val("t5_no_stale", 32'(xfer_dat.size()), 32'd0);
      check_val("t5_rv_post",  32'(res_valid), 32'd0);
      check_val("t5_ready",    32'(cmd_ready), 32'd1);

      // 6: alternating ready, random commands, scoreboard order
      xfer_dat.delete(); xfer_cyc.delete();
      alt_en = 1'b1;
      for (int i = 0; i < 8; i++) send(4'($urandom_range(15)), 2'($urandom_range(3)));
      wait_xfers(8, 80);
      check_val("t6_sb_empty", 32'(exp_q.size()), 32'd0);
      alt_en = 1'b0;
      repeat (2) tick();
      check_val("t6_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rotate_issue_queue
